// File: rtl/wsg_voice_sequencer.sv
// Voice sequencer: time-multiplexes three waveform voices onto one shared
// sound ROM, then scales each 4-bit sample by its voice volume and sums the
// three products into a 10-bit mixed sample once per sample period.
// Latency: a sample tick in cycle T produces sample_valid in cycle T+5.
// No backpressure: the consumer must take sample_out while sample_valid is high.
module wsg_voice_sequencer #(
  parameter int TICK_DIV = 1042
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] addr_1,
  input  logic [7:0] addr_2,
  input  logic [7:0] addr_3,
  input  logic [3:0] vol_1,
  input  logic [3:0] vol_2,
  input  logic [3:0] vol_3,
  output logic [7:0] rom_addr,
  output logic       rom_en,
  input  logic [7:0] rom_data,
  output logic       accum_adv,
  output logic [9:0] sample_out,
  output logic       sample_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    V1   = 3'd1,
    V2   = 3'd2,
    V3   = 3'd3,
    LAST = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] div_cnt;
  logic        tick;

  logic [7:0]  snap_addr1;
  logic [7:0]  snap_addr2;
  logic [7:0]  snap_addr3;
  logic [3:0]  snap_vol1;
  logic [3:0]  snap_vol2;
  logic [3:0]  snap_vol3;
  logic [9:0]  mix;

  logic [3:0]  rom_nib;
  logic        unused_rom_hi;

  // Only the low nibble of each ROM byte is a sample; the high nibble is spare.
  assign rom_nib       = rom_data[3:0];
  assign unused_rom_hi = ^rom_data[7:4];

  // 4x4 unsigned product; 15*15 = 225 fits in 8 bits.
  function automatic logic [7:0] scale(input logic [3:0] smp, input logic [3:0] vol);
    return {4'd0, smp} * {4'd0, vol};
  endfunction

  // Sample strobe: last count of the divider, only while enabled.
  assign tick = en && (div_cnt == 16'(TICK_DIV - 1));

  // The voice accumulators advance at the edge that closes the snapshot cycle,
  // so the snapshot taken on that same edge still holds the pre-advance address.
  assign accum_adv = tick && (state == IDLE);

  // The frame is considered in progress from its tick cycle through OUT.
  assign busy = (state != IDLE) || accum_adv;

  // Sample-period divider; disabling clears and holds it so the first tick
  // after enable lands a full period later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Frame FSM: snapshot voices, issue three ROM reads, accumulate products
  // one cycle behind each read, then publish the mix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rom_addr     <= '0;
      rom_en       <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      snap_addr1   <= '0;
      snap_addr2   <= '0;
      snap_addr3   <= '0;
      snap_vol1    <= '0;
      snap_vol2    <= '0;
      snap_vol3    <= '0;
      mix          <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            snap_addr1 <= addr_1;
            snap_addr2 <= addr_2;
            snap_addr3 <= addr_3;
            snap_vol1  <= vol_1;
            snap_vol2  <= vol_2;
            snap_vol3  <= vol_3;
            mix        <= '0;
            state      <= V1;
          end
        end
        V1: begin
          rom_addr <= snap_addr1;
          rom_en   <= 1'b1;
          state    <= V2;
        end
        V2: begin
          rom_addr <= snap_addr2;
          rom_en   <= 1'b1;
          mix      <= mix + {2'b00, scale(rom_nib, snap_vol1)};
          state    <= V3;
        end
        V3: begin
          rom_addr <= snap_addr3;
          rom_en   <= 1'b1;
          mix      <= mix + {2'b00, scale(rom_nib, snap_vol2)};
          state    <= LAST;
        end
        LAST: begin
          // rom_addr deliberately keeps voice 3's address while idle.
          rom_en       <= 1'b0;
          sample_out   <= mix + {2'b00, scale(rom_nib, snap_vol3)};
          sample_valid <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A frame is shorter than the shortest sample period, so a tick can never
  // arrive while a frame is still running.
  a_tick_in_idle: assert property (@(posedge clk) disable iff (rst) tick |-> state == IDLE);

endmodule

// File: tb/tb_wsg_voice_sequencer.sv
// Bench for wsg_voice_sequencer with TICK_DIV=16 and a combinational ROM model
// driven from the DUT's registered address; a frame-level reference model is
// compared every cycle, alongside hand-computed literal expectations.
module tb_wsg_voice_sequencer;

  localparam int TD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] addr_1 = 8'h03;
  logic [7:0] addr_2 = 8'h25;
  logic [7:0] addr_3 = 8'hEF;
  logic [3:0] vol_1  = 4'd1;
  logic [3:0] vol_2  = 4'd2;
  logic [3:0] vol_3  = 4'd3;
  logic [7:0] rom_addr;
  logic       rom_en;
  logic [7:0] rom_data;
  logic       accum_adv;
  logic [9:0] sample_out;
  logic       sample_valid;
  logic       busy;

  // 0: data = addr[3:0], 1: data = 8'hFF, 2: data = 8'h0F
  int rom_mode = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wsg_voice_sequencer #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .addr_1       (addr_1),
    .addr_2       (addr_2),
    .addr_3       (addr_3),
    .vol_1        (vol_1),
    .vol_2        (vol_2),
    .vol_3        (vol_3),
    .rom_addr     (rom_addr),
    .rom_en       (rom_en),
    .rom_data     (rom_data),
    .accum_adv    (accum_adv),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  function automatic logic [7:0] rom_fn(input int mode, input logic [7:0] a);
    logic [7:0] r;
    case (mode)
      1:       r = 8'hFF;
      2:       r = 8'h0F;
      default: r = {4'h0, a[3:0]};
    endcase
    return r;
  endfunction

  assign rom_data = rom_fn(rom_mode, rom_addr);

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state: the frame is described by its age in cycles since
  // the tick (0..5) and the voices captured at the tick.
  int         run = 0;
  int         age = -1;
  logic [7:0] m_addr [3];
  int         m_vol  [3];
  int         partial = 0;
  int         cur_sample = 0;
  logic [7:0] last_addr = 8'h00;

  task automatic model_and_compare();
    bit e_tick;
    bit e_rom_en;
    e_tick = 1'b0;
    if (rst) begin
      run = 0; age = -1; partial = 0; cur_sample = 0; last_addr = 8'h00;
    end else begin
      run = en ? run + 1 : 0;
      e_tick = en && (run % TD == 0);
      if (e_tick) begin
        age = 0;
        m_addr[0] = addr_1; m_addr[1] = addr_2; m_addr[2] = addr_3;
        m_vol[0] = int'(vol_1); m_vol[1] = int'(vol_2); m_vol[2] = int'(vol_3);
        partial = 0;
      end
    end
    e_rom_en = (age >= 2 && age <= 4);
    if (e_rom_en) begin
      last_addr = m_addr[age-2];
      partial += int'(rom_fn(rom_mode, last_addr) & 8'h0F) * m_vol[age-2];
    end
    if (age == 5) cur_sample = partial;
    chk("accum_adv", int'(accum_adv), int'(e_tick));
    chk("busy", int'(busy), (age >= 0) ? 1 : 0);
    chk("rom_en", int'(rom_en), int'(e_rom_en));
    chk("rom_addr", int'(rom_addr), int'(last_addr));
    chk("sample_valid", int'(sample_valid), (age == 5) ? 1 : 0);
    chk("sample_out", int'(sample_out), cur_sample);
    if (age >= 0) begin
      age++;
      if (age > 5) age = -1;
    end
  endtask

  // Cycles (negedges) until accum_adv is seen, -1 on timeout.
  task automatic count_to_adv(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (accum_adv) begin
        n = i;
        return;
      end
    end
    chk("adv_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int v);
    v = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        v = int'(sample_out);
        return;
      end
    end
    chk("valid_timeout", 0, 1);
  endtask

  task automatic step_in(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic stimulus();
    int n;
    int v;
    int advs;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    step_in(1);
    rst = 1'b0;
    en  = 1'b1;

    // First tick in the 16th enabled cycle, then ROM order and mix 3+10+45
    count_to_adv(n);
    chk("first_tick_cycles", n, 16);
    @(negedge clk);
    @(negedge clk);
    chk("rom_addr_v1", int'(rom_addr), 8'h03);
    @(negedge clk);
    chk("rom_addr_v2", int'(rom_addr), 8'h25);
    @(negedge clk);
    chk("rom_addr_v3", int'(rom_addr), 8'hEF);
    @(negedge clk);
    chk("valid_latency", int'(sample_valid), 1);
    chk("mix_58", int'(sample_out), 58);
    count_to_adv(n);
    chk("tick_period", n + 5, 16);

    // Full-scale mix, then upper ROM nibble ignored
    wait_valid(v);
    step_in(1);
    vol_1 = 4'd15; vol_2 = 4'd15; vol_3 = 4'd15; rom_mode = 1;
    wait_valid(v);
    chk("mix_675_ff", v, 675);
    step_in(1);
    rom_mode = 2;
    wait_valid(v);
    chk("mix_675_0f", v, 675);

    // vol_2 changed during V2 does not affect the running frame
    step_in(1);
    rom_mode = 0; vol_1 = 4'd1; vol_2 = 4'd0; vol_3 = 4'd3;
    count_to_adv(n);
    step_in(2);
    vol_2 = 4'd15;
    wait_valid(v);
    chk("vol2_snapshot_old", v, 48);
    wait_valid(v);
    chk("vol2_snapshot_new", v, 123);

    // en dropped in V3: frame still completes, then no ticks
    count_to_adv(n);
    step_in(3);
    en = 1'b0;
    wait_valid(v);
    chk("en_drop_frame_done", v, 123);
    advs = 0;
    repeat (100) begin
      @(negedge clk);
      if (accum_adv) advs++;
    end
    chk("no_adv_while_disabled", advs, 0);
    step_in(1);
    en = 1'b1;
    count_to_adv(n);
    chk("reenable_first_tick", n, 16);

    // rst in LAST: outputs clear immediately, frame discarded
    wait_valid(v);
    count_to_adv(n);
    step_in(4);
    rst = 1'b1;
    #1;
    chk("rst_mid_sample_out", int'(sample_out), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_rom_en", int'(rom_en), 0);
    step_in(3);
    rst = 1'b0;
    count_to_adv(n);
    chk("post_rst_first_tick", n, 16);
    wait_valid(v);
    chk("post_rst_mix", v, 123);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        model_and_compare();
      end
      stimulus();
      begin
        #200000;
        chk("global_timeout", 0, 1);
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
